// File: rtl/dsp_arb_pkg.sv
// Shared types and constants for the two-requester DSP48E1 scheduler:
// op codes, per-op slice control encodings and the fixed slice latency.
package dsp_arb_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MAC_C = 2'd1,
        OP_C_SUB = 2'd2,
        OP_CONST = 2'd3
    } op_e;

    typedef struct packed {
        logic [4:0] inmode;
        logic [3:0] alumode;
        logic [6:0] opmode;
    } dsp_ctrl_t;

    localparam int          DSP_LAT = 2;
    localparam logic [47:0] C_CONST = 48'h000000095514;

    localparam logic [4:0] INMODE_ALL   = 5'b00000;
    localparam logic [3:0] ALUMODE_ADD  = 4'h0;
    localparam logic [3:0] ALUMODE_ZSUB = 4'h3;
    localparam logic [6:0] OPMODE_M     = 7'h05;
    localparam logic [6:0] OPMODE_C_M   = 7'h35;
    localparam logic [6:0] OPMODE_C     = 7'h30;

    function automatic dsp_ctrl_t encode_op(input op_e op);
        dsp_ctrl_t ctrl;
        ctrl.inmode = INMODE_ALL;
        case (op)
            OP_MAC_C: begin ctrl.opmode = OPMODE_C_M; ctrl.alumode = ALUMODE_ADD;  end
            OP_C_SUB: begin ctrl.opmode = OPMODE_C_M; ctrl.alumode = ALUMODE_ZSUB; end
            OP_CONST: begin ctrl.opmode = OPMODE_C;   ctrl.alumode = ALUMODE_ADD;  end
            default:  begin ctrl.opmode = OPMODE_M;   ctrl.alumode = ALUMODE_ADD;  end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// pointer to the most recently granted requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves grant unassigned (no latch).
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11)
                grant = last ? 2'b01 : 2'b10;
            else
                grant = valid;
        end
    end

    // last = 1 after reset so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (|grant)
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            last <= grant[1];
    end

endmodule

// File: rtl/dsp_arbiter.sv
// Shares one external DSP48E1 slice between two requesters: grants one op per
// cycle, encodes it onto the slice ports and routes each P back by tag.
module dsp_arbiter #(
    parameter int DSP_LAT = dsp_arb_pkg::DSP_LAT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [29:0]      req0_a,
    input  logic [17:0]      req0_b,
    input  logic [1:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [29:0]      req1_a,
    input  logic [17:0]      req1_b,
    input  logic [1:0]       req1_op,

    output logic             rsp0_valid,
    output logic [47:0]      rsp0_p,
    output logic             rsp1_valid,
    output logic [47:0]      rsp1_p,

    output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1,
    output logic             idle,

    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [4:0]       dsp_inmode,
    output logic [3:0]       dsp_alumode,
    output logic [6:0]       dsp_opmode,
    input  logic [47:0]      dsp_p
);

    import dsp_arb_pkg::*;

    logic [1:0]         grant;
    logic               any_grant;
    logic               grant_id;
    dsp_ctrl_t          ctrl;
    logic [DSP_LAT-1:0] tag_vld;
    logic [DSP_LAT-1:0] tag_id;
    logic               out_vld;
    logic               out_id;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign any_grant  = |grant;
    assign grant_id   = grant[1];

    // Idle slice inputs present a harmless 0*0 multiply.
    always_comb begin
        dsp_a = '0;
        dsp_b = '0;
        ctrl  = encode_op(OP_MUL);
        if (grant[0]) begin
            dsp_a = req0_a;
            dsp_b = req0_b;
            ctrl  = encode_op(op_e'(req0_op));
        end else if (grant[1]) begin
            dsp_a = req1_a;
            dsp_b = req1_b;
            ctrl  = encode_op(op_e'(req1_op));
        end
    end

    assign dsp_inmode  = ctrl.inmode;
    assign dsp_alumode = ctrl.alumode;
    assign dsp_opmode  = ctrl.opmode;

    // Tag pipeline mirrors the slice latency so the final stage lines up with a valid P.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[DSP_LAT-2:0], any_grant};
            tag_id  <= {tag_id[DSP_LAT-2:0], grant_id};
        end
    end

    assign out_vld = tag_vld[DSP_LAT-1];
    assign out_id  = tag_id[DSP_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_p     <= '0;
            rsp1_p     <= '0;
        end else begin
            rsp0_valid <= out_vld & ~out_id;
            rsp1_valid <= out_vld & out_id;
            if (out_vld & ~out_id)
                rsp0_p <= dsp_p;
            if (out_vld & out_id)
                rsp1_p <= dsp_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (grant[0])
                issue_cnt0 <= issue_cnt0 + CNT_W'(1);
            if (grant[1])
                issue_cnt1 <= issue_cnt1 + CNT_W'(1);
        end
    end

    assign idle = ~(|tag_vld) & ~rsp0_valid & ~rsp1_valid;

endmodule
